// File: rtl/tone_speaker_driver_if.sv
// Control and I2S pin bundle for tone_speaker_driver.
// The master drives tone/volume/mute; the slave (the driver) returns busy and the DAC pins.
interface tone_speaker_driver_if;
  logic [31:0] tone;
  logic [2:0]  volume;
  logic        mute;
  logic        busy;
  logic        audio_mclk;
  logic        audio_sck;
  logic        audio_lrck;
  logic        audio_sdin;

  modport master (
    output tone, volume, mute,
    input  busy, audio_mclk, audio_sck, audio_lrck, audio_sdin
  );

  modport slave (
    input  tone, volume, mute,
    output busy, audio_mclk, audio_sck, audio_lrck, audio_sdin
  );
endinterface

// File: rtl/tone_speaker_driver.sv
// Square-wave tone generator feeding an I2S DAC (mclk = clk/4, sck = clk/8, lrck = clk/512).
// Optional macro SPK_RAMP_EN: slews the sample magnitude by at most 0x0100 per half-frame.
module tone_speaker_driver #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned SILENCE_HZ = 20000,
  parameter logic [15:0] MAX_AMP    = 16'h3FFF
) (
  input logic                  clk,
  input logic                  rst,
  tone_speaker_driver_if.slave spk
);

  localparam logic [1:0]  IDLE      = 2'd0;
  localparam logic [1:0]  DIV       = 2'd1;
  localparam logic [1:0]  COMMIT    = 2'd2;
  localparam logic [31:0] DIVIDEND  = 32'(CLK_HZ);
  localparam logic [31:0] SILENCE   = 32'(SILENCE_HZ);
  localparam logic [15:0] RAMP_STEP = 16'h0100;

  logic [8:0]  clk_cnt_reg, clk_cnt_next;
  logic [1:0]  state_reg, state_next;
  logic [31:0] tone_q_reg, tone_q_next;
  logic        silent_reg, silent_next;
  logic [31:0] half_period_reg, half_period_next;
  logic [31:0] wave_cnt_reg, wave_cnt_next;
  logic        phase_reg, phase_next;
  logic [31:0] dvd_reg, dvd_next;
  logic [31:0] rem_reg, rem_next;
  logic [31:0] quo_reg, quo_next;
  logic [4:0]  bit_cnt_reg, bit_cnt_next;
  logic [15:0] frame_sample_reg, frame_sample_next;
  logic        sdin_reg, sdin_next;

  logic        wave_clear;
  logic [32:0] trial;
  logic [32:0] divisor;
  logic        trial_ge;
  logic [31:0] trial_sub;
  logic        latch;
  logic [4:0]  slot_next;
  logic [31:0] slot_bits;
  logic [7:0][15:0] amp_table;
  logic [15:0] amp;
  logic [15:0] target_mag;
  logic [15:0] mag;
  logic [15:0] sample;

  // Restoring division step: shift in the next dividend bit, subtract if it fits.
  // The remainder always stays below the divisor, so 32 bits of difference suffice.
  assign trial     = {rem_reg, dvd_reg[31]};
  assign divisor   = {tone_q_reg, 1'b0};
  assign trial_ge  = (trial >= divisor);
  assign trial_sub = trial[31:0] - divisor[31:0];

  always_comb begin
    state_next       = state_reg;
    tone_q_next      = tone_q_reg;
    silent_next      = silent_reg;
    half_period_next = half_period_reg;
    dvd_next         = dvd_reg;
    rem_next         = rem_reg;
    quo_next         = quo_reg;
    bit_cnt_next     = bit_cnt_reg;
    wave_clear       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (spk.tone != tone_q_reg) begin
          tone_q_next = spk.tone;
          if (spk.tone == 32'd0 || spk.tone >= SILENCE) begin
            silent_next = 1'b1;
          end else begin
            state_next   = DIV;
            dvd_next     = DIVIDEND;
            rem_next     = 32'd0;
            quo_next     = 32'd0;
            bit_cnt_next = 5'd0;
          end
        end
      end
      DIV: begin
        dvd_next     = {dvd_reg[30:0], 1'b0};
        rem_next     = trial_ge ? trial_sub : trial[31:0];
        quo_next     = {quo_reg[30:0], trial_ge};
        bit_cnt_next = bit_cnt_reg + 5'd1;
        if (bit_cnt_reg == 5'd31) begin
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        half_period_next = quo_reg;
        silent_next      = 1'b0;
        wave_clear       = 1'b1;
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Half-period counter; held at zero while silent so a new tone starts on a clean edge.
  always_comb begin
    wave_cnt_next = wave_cnt_reg + 32'd1;
    phase_next    = phase_reg;
    if (silent_reg || wave_clear) begin
      wave_cnt_next = 32'd0;
      phase_next    = 1'b0;
    end else if (wave_cnt_reg == half_period_reg - 32'd1) begin
      wave_cnt_next = 32'd0;
      phase_next    = ~phase_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_amp
      if (gi == 0) begin : g_zero
        assign amp_table[gi] = 16'h0000;
      end else begin : g_shift
        assign amp_table[gi] = MAX_AMP >> (7 - gi);
      end
    end
  endgenerate

  assign amp        = amp_table[spk.volume];
  assign target_mag = (silent_reg || spk.mute || spk.volume == 3'd0) ? 16'h0000 : amp;
  assign latch      = (clk_cnt_reg[7:0] == 8'hFF);

`ifdef SPK_RAMP_EN
  logic [15:0] ramp_reg, ramp_next;

  always_comb begin
    ramp_next = ramp_reg;
    if (ramp_reg < target_mag) begin
      ramp_next = (target_mag - ramp_reg > RAMP_STEP) ? ramp_reg + RAMP_STEP : target_mag;
    end else if (ramp_reg > target_mag) begin
      ramp_next = (ramp_reg - target_mag > RAMP_STEP) ? ramp_reg - RAMP_STEP : target_mag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ramp_reg <= 16'h0000;
    end else if (latch) begin
      ramp_reg <= ramp_next;
    end
  end

  assign mag = ramp_next;
`else
  assign mag = target_mag;
`endif

  assign sample = phase_reg ? mag : (16'h0000 - mag);

  // I2S slot map: slot 0 is the one-bit delay, slots 1..16 carry the word MSB first.
  generate
    for (gi = 0; gi < 32; gi++) begin : g_slot
      if (gi >= 1 && gi <= 16) begin : g_data
        assign slot_bits[gi] = frame_sample_reg[16 - gi];
      end else begin : g_pad
        assign slot_bits[gi] = 1'b0;
      end
    end
  endgenerate

  assign clk_cnt_next      = clk_cnt_reg + 9'd1;
  assign frame_sample_next = latch ? sample : frame_sample_reg;
  assign slot_next         = clk_cnt_reg[7:3] + 5'd1;
  assign sdin_next         = (clk_cnt_reg[2:0] == 3'b111) ? slot_bits[slot_next] : sdin_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_cnt_reg      <= 9'd0;
      state_reg        <= IDLE;
      tone_q_reg       <= SILENCE;
      silent_reg       <= 1'b1;
      half_period_reg  <= 32'd0;
      wave_cnt_reg     <= 32'd0;
      phase_reg        <= 1'b0;
      dvd_reg          <= 32'd0;
      rem_reg          <= 32'd0;
      quo_reg          <= 32'd0;
      bit_cnt_reg      <= 5'd0;
      frame_sample_reg <= 16'h0000;
      sdin_reg         <= 1'b0;
    end else begin
      clk_cnt_reg      <= clk_cnt_next;
      state_reg        <= state_next;
      tone_q_reg       <= tone_q_next;
      silent_reg       <= silent_next;
      half_period_reg  <= half_period_next;
      wave_cnt_reg     <= wave_cnt_next;
      phase_reg        <= phase_next;
      dvd_reg          <= dvd_next;
      rem_reg          <= rem_next;
      quo_reg          <= quo_next;
      bit_cnt_reg      <= bit_cnt_next;
      frame_sample_reg <= frame_sample_next;
      sdin_reg         <= sdin_next;
    end
  end

  assign spk.busy       = (state_reg == DIV);
  assign spk.audio_mclk = clk_cnt_reg[1];
  assign spk.audio_sck  = clk_cnt_reg[2];
  assign spk.audio_lrck = clk_cnt_reg[8];
  assign spk.audio_sdin = sdin_reg;

endmodule

// File: tb/tb_tone_speaker_driver.sv
// Self-checking bench for tone_speaker_driver: tone vectors, I2S word scoreboard,
// silence, mid-divide tone change and mid-divide reset.
module tb_tone_speaker_driver;

  localparam int HF = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tone_speaker_driver_if bus ();

  tone_speaker_driver dut (
    .clk (clk),
    .rst (rst),
    .spk (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Mirror of the free-running frame counter.
  int unsigned tb_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tb_cnt <= 0;
    else     tb_cnt <= tb_cnt + 1;
  end

  // Reference model of the waveform.
  bit          m_valid  = 1'b1;
  bit          m_silent = 1'b1;
  int unsigned m_commit = 0;
  int unsigned m_hp     = 1;

  typedef struct {
    bit          valid;
    logic [15:0] val;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [31:0] tone;
    logic [2:0]  vol;
    logic        mute;
    logic        divides;
    logic        silent;
    logic [31:0] hp;
  } vec_t;
  vec_t vec[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cnt %0d: got %0h expected %0h", name, tb_cnt, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_sample(input int unsigned e);
    logic [15:0] a;
    int unsigned n;
    if (m_silent || bus.mute || bus.volume == 3'd0) return 16'h0000;
    a = 16'h3FFF >> (7 - int'(bus.volume));
    n = (e - m_commit - 1) / m_hp;
    return (n % 2 == 1) ? a : (16'h0000 - a);
  endfunction

  // Monitor: clock pins every cycle, scoreboard push at each latch, word check per half-frame.
  logic [31:0] word = 32'd0;
  initial begin
    logic [31:0] w;
    sb_t s;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("clocks", {29'd0, bus.audio_lrck, bus.audio_sck, bus.audio_mclk},
              {29'd0, tb_cnt[8], tb_cnt[2], tb_cnt[1]});
        if (tb_cnt[7:0] == 8'hFF) begin
          s.valid = m_valid;
          s.val   = m_valid ? exp_sample(tb_cnt) : 16'h0000;
          sb_q.push_back(s);
        end
        if (tb_cnt[2:0] == 3'd3) begin
          w    = {word[30:0], bus.audio_sdin};
          word = w;
          if (tb_cnt[7:0] == 8'hFB) begin
            check("framing", {16'd0, w[31], w[14:0]}, 32'd0);
            if (sb_q.size() == 0) begin
              check("sample_after_reset", {16'd0, w[30:15]}, 32'd0);
            end else begin
              s = sb_q.pop_front();
              if (s.valid) check("sample", {16'd0, w[30:15]}, {16'd0, s.val});
            end
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic watch_busy(input int unsigned c, output int cnt, output int first);
    cnt   = 0;
    first = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.busy) begin
        if (first < 0) first = int'(tb_cnt - c);
        cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cnt(input int unsigned target);
    int guard;
    guard = 0;
    @(negedge clk);
    while (tb_cnt != target && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("wait_bound", {31'd0, (tb_cnt != target)}, 32'd0);
  endtask

  initial begin
    int unsigned c;
    int bc, bf;

    vec[0] = '{32'd523,   3'd7, 1'b0, 1'b1, 1'b0, 32'd95602};
    vec[1] = '{32'd440,   3'd4, 1'b0, 1'b1, 1'b0, 32'd113636};
    vec[2] = '{32'd19999, 3'd7, 1'b0, 1'b1, 1'b0, 32'd2500};
    vec[3] = '{32'd19999, 3'd2, 1'b1, 1'b0, 1'b0, 32'd2500};
    vec[4] = '{32'd19999, 3'd2, 1'b0, 1'b0, 1'b0, 32'd2500};
    vec[5] = '{32'd20000, 3'd7, 1'b0, 1'b0, 1'b1, 32'd2500};
    vec[6] = '{32'd0,     3'd5, 1'b0, 1'b0, 1'b1, 32'd2500};
    vec[7] = '{32'd1000,  3'd0, 1'b0, 1'b1, 1'b0, 32'd50000};
    vec[8] = '{32'd523,   3'd7, 1'b0, 1'b1, 1'b0, 32'd95602};

    bus.tone   = 32'd0;
    bus.volume = 3'd7;
    bus.mute   = 1'b0;
    tick(3);
    check("reset_pins", {27'd0, bus.busy, bus.audio_mclk, bus.audio_sck, bus.audio_lrck, bus.audio_sdin}, 32'd0);
    check("reset_half_period", dut.half_period_reg, 32'd0);
    check("reset_silent", 32'(dut.silent_reg), 32'd1);
    rst = 1'b0;
    tick(HF * 2);

    for (int i = 0; i < 9; i++) begin
      m_valid    = 1'b0;
      bus.tone   = vec[i].tone;
      bus.volume = vec[i].vol;
      bus.mute   = vec[i].mute;
      c = tb_cnt;
      watch_busy(c, bc, bf);
      check("busy_cycles", 32'(bc), vec[i].divides ? 32'd32 : 32'd0);
      if (vec[i].divides) check("busy_start", 32'(bf), 32'd1);
      check("half_period", dut.half_period_reg, vec[i].hp);
      check("silent", 32'(dut.silent_reg), 32'(vec[i].silent));
      if (vec[i].divides) begin
        m_commit = c + 33;
        m_hp     = vec[i].hp;
      end
      m_silent = vec[i].silent;
      m_valid  = 1'b1;
      $display("vec %0d tone %0d vol %0d mute %0d half_period %0d busy %0d", i,
               vec[i].tone, vec[i].vol, vec[i].mute, dut.half_period_reg, bc);
      tick(HF * 12);
    end

    // 523 -> silence: fast silent flag, no divide, period retained.
    m_valid  = 1'b0;
    bus.tone = 32'd20000;
    c = tb_cnt;
    @(negedge clk);
    @(negedge clk);
    check("silence_fast", 32'(dut.silent_reg), 32'd1);
    @(posedge clk);
    #1;
    watch_busy(tb_cnt, bc, bf);
    check("silence_no_busy", 32'(bc), 32'd0);
    check("silence_half_period", dut.half_period_reg, 32'd95602);
    m_silent = 1'b1;
    m_valid  = 1'b1;
    $display("seq silence half_period %0d", dut.half_period_reg);
    tick(HF * 3);

    // Tone change while dividing: first result commits, second divide follows.
    m_valid  = 1'b0;
    bus.tone = 32'd523;
    c = tb_cnt;
    tick(10);
    bus.tone = 32'd587;
    wait_cnt(c + 34);
    check("div_change_first", dut.half_period_reg, 32'd95602);
    check("div_change_gap", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("div_change_restart", 32'(bus.busy), 32'd1);
    wait_cnt(c + 68);
    check("div_change_second", dut.half_period_reg, 32'd85178);
    @(posedge clk);
    #1;
    m_commit = c + 67;
    m_hp     = 85178;
    m_silent = 1'b0;
    m_valid  = 1'b1;
    $display("seq tone change during divide half_period %0d", dut.half_period_reg);
    tick(HF * 3);

    // Reset in the middle of a divide.
    m_valid    = 1'b0;
    bus.volume = 3'd4;
    bus.tone   = 32'd440;
    tick(10);
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_pins", {27'd0, bus.busy, bus.audio_mclk, bus.audio_sck, bus.audio_lrck, bus.audio_sdin}, 32'd0);
    check("midrst_half_period", dut.half_period_reg, 32'd0);
    check("midrst_silent", 32'(dut.silent_reg), 32'd1);
    sb_q.delete();
    tick(3);
    m_commit = 33;
    m_hp     = 113636;
    m_silent = 1'b0;
    m_valid  = 1'b1;
    rst = 1'b0;
    wait_cnt(40);
    check("after_reset_half_period", dut.half_period_reg, 32'd113636);
    $display("seq reset mid-divide half_period %0d", dut.half_period_reg);
    tick(HF * 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tone_speaker_driver.md
Name: tone_speaker_driver

Overview:
Downstream consumer of the beat-to-tone lookup. Takes the 32-bit tone frequency in Hz and produces a square-wave audio sample, then serialises it onto the board's I2S DAC pins (mclk/lrck/sck/sdin).
- A sequential restoring divider converts the frequency to a half-period count whenever the tone changes.
- The value 20000 is the design's silence code.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz.
SILENCE_HZ, 20000, any tone >= this value, or tone == 0, is treated as silence.
MAX_AMP, 16'h3FFF, peak amplitude at volume 7 (positive, 16-bit two's complement).

Ports:
clk  in  1  system clock.
rst  in  1  reset, asynchronous, active-high.
tone  in  32  requested frequency in Hz, from the beat-to-tone lookup.
volume  in  3  0 = silent, 1..7 = increasing amplitude.
mute  in  1  forces zero samples while high.
busy  out  1  high while the divider is running.
audio_mclk  out  1  DAC master clock = clk/4.
audio_sck  out  1  DAC bit clock = clk/8.
audio_lrck  out  1  DAC word select = clk/512; 0 = left, 1 = right.
audio_sdin  out  1  DAC serial data.

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-high.
- Reset values: all outputs 0; clk_cnt 0; tone_q = SILENCE_HZ; silent = 1; half_period = 0; phase = 0; state = IDLE.
- Clock divider: free-running 9-bit clk_cnt.
  - audio_mclk = clk_cnt[1], audio_sck = clk_cnt[2], audio_lrck = clk_cnt[8]; all registered.
  - Each half-frame is 32 sck periods.
- Tone FSM, states IDLE, DIV, COMMIT:
  - IDLE: if tone != tone_q, latch tone_q = tone.
    - If the new tone is 0 or >= SILENCE_HZ: set silent = 1, stay in IDLE, do not divide; half_period is left unchanged.
    - Otherwise go to DIV.
  - DIV: restoring division CLK_HZ / (2*tone_q), one quotient bit per cycle, exactly 32 cycles; busy = 1 throughout.
  - COMMIT: one cycle. half_period = quotient (truncated), silent = 0, wave counter = 0, phase = 0; return to IDLE.
  - Tone changes during DIV/COMMIT are ignored; the new value is picked up on the first IDLE cycle after COMMIT.
  - Latency from a tone change to new waveform: 34 cycles (1 IDLE + 32 DIV + 1 COMMIT).
- Wave generator:
  - 32-bit counter increments every cycle.
  - When counter == half_period-1: counter clears and phase toggles.
  - Frozen at 0 while silent = 1.
- Amplitude:
  - amp = 0 if volume == 0, else MAX_AMP >> (7 - volume).
  - sample = 0 if silent | mute, else phase ? +amp : -amp (two's complement, 16 bit).
- Sample latch: sample is captured into frame_sample only when clk_cnt[7:0] == 8'hFF (end of each half-frame). Both channels carry the same value.
- Serialiser, I2S with one-bit delay:
  - Within a half-frame, bit slot k = clk_cnt[7:3].
  - Slot 0 outputs 0; slots 1..16 output frame_sample[15..0] MSB first; slots 17..31 output 0.
  - audio_sdin updates on the cycle where clk_cnt[2:0] == 3'b111, i.e. on the sck falling edge.
- Reset mid-operation: the divider aborts; all state returns to reset values immediately.

Optional Feature:
SPK_RAMP_EN
- Defined:
  - The magnitude used for the sample moves toward the target magnitude by at most 16'h0100 per half-frame (updated at the sample latch).
  - Target magnitude is 0 when silent | mute | volume == 0, else amp.
  - Sign is still taken from phase.
  - Ramp register resets to 0.
- Not defined: magnitude equals target immediately; no ramp register is synthesised.

Test Plan:
- Reset: assert rst mid-DIV -> all outputs 0, busy 0; after release, the first half-frame's audio_sdin is all zeros.
- tone = 523, volume 7 -> busy high 32 cycles; half_period = 95602; phase toggles every 95602 cycles; serialised samples 16'h3FFF / 16'hC001.
- tone = 440, volume 4 -> half_period = 113636; samples 16'h07FF / 16'hF801; bits appear in slots 1..16 MSB first, slot 0 and slots 17..31 are 0.
- tone 523 then 20000 -> silent within 2 cycles of change; next latched sample 0; half_period still 95602; no busy pulse.
- tone changes 523 -> 587 during DIV -> first COMMIT yields 95602; next DIV starts next IDLE cycle and yields 85178 (100e6/1174).
- With SPK_RAMP_EN: volume 7, tone 523 from silence -> magnitude 0x0100, 0x0200, ... per half-frame, saturating at 0x3FFF after 64 half-frames. Without the macro: 0x3FFF on the first latch.
